seq_detector: RTL and testbench

Serial bit-pattern detector. Samples one bit per clock from a serial input stream and pulses its output for one cycle each time a programmable pattern has been received. Matches may overlap or not, selected by parameter. Sits behind a serial front end as a frame-marker or sync-word finder. An optional saturating match counter can be compiled in.

---
 rtl/seq_detector.sv | 128 ++++++++++++
 tb/tb_seq_detector.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - serial bit-pattern detector with KMP fallback
//
// Purpose:
//   Samples one serial bit per rising edge and emits a registered one-cycle
//   pulse each time PATTERN (MSB received first) has been seen. The state is
//   the length of the longest pattern prefix that matches the most recent
//   input bits. The next-state table is derived from PATTERN at elaboration
//   time, so any pattern of width 2..16 is handled without hand-written arcs.
//
// Parameters:
//   PATTERN_W  pattern length in bits (2..16)
//   PATTERN    pattern to detect, MSB first on the wire
//   OVERLAP    1: overlapping matches, 0: non-overlapping matches
//   COUNT_W    match counter width (used only with SEQ_DET_COUNT_EN)
//
// Ports:
//   i_clk           sole clock, rising edge
//   i_rst           synchronous active-high reset
//   i_sequence_in   serial data bit
//   o_detector_out  registered one-cycle match pulse
//   o_match_count   saturating match count (only with SEQ_DET_COUNT_EN)
//
// Build option:
//   SEQ_DET_COUNT_EN  compiles in the saturating match counter and its port.

module seq_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1101,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int                   COUNT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_sequence_in,
  output logic               o_detector_out
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [COUNT_W-1:0] o_match_count
`endif
);

  localparam int SW = $clog2(PATTERN_W);

  typedef logic [SW-1:0] state_t;
  localparam state_t S0 = '0;

  // Bit i of the pattern counted from the first bit received.
  function automatic logic pbit(input int i);
    logic [15:0] p;
    p = 16'(PATTERN);
    return p[4'(PATTERN_W - 1 - i)];
  endfunction

  // Bit idx of the string formed by the first k pattern bits followed by b.
  function automatic logic sbit(input int k, input logic b, input int idx);
    return (idx < k) ? pbit(idx) : b;
  endfunction

  // Longest j <= max_j such that the last j bits of (prefix_k, b) equal the
  // first j bits of the pattern.
  function automatic int border(input int k, input logic b, input int max_j);
    int   best;
    logic ok;
    best = 0;
    for (int j = 1; j <= max_j; j++) begin
      ok = 1'b1;
      for (int i = 0; i < j; i++) begin
        if (sbit(k, b, k + 1 - j + i) != pbit(i)) ok = 1'b0;
      end
      if (ok) best = j;
    end
    return best;
  endfunction

  // State reached after a full match: the longest proper border of the
  // pattern when overlapping, otherwise start over.
  localparam int FALLBACK = OVERLAP ?
    border(PATTERN_W - 1, pbit(PATTERN_W - 1), PATTERN_W - 1) : 0;

  // Table indexed by {state, bit}.
  state_t                 w_next_tbl [2*PATTERN_W];
  logic [2*PATTERN_W-1:0] w_hit_tbl;

  for (genvar gk = 0; gk < PATTERN_W; gk++) begin : g_state
    for (genvar gb = 0; gb < 2; gb++) begin : g_bit
      localparam int J = border(gk, (gb != 0), gk + 1);
      assign w_hit_tbl[2*gk+gb]  = (J == PATTERN_W);
      assign w_next_tbl[2*gk+gb] = state_t'((J == PATTERN_W) ? FALLBACK : J);
    end
  end

  state_t        r_state;
  logic          r_detector_out;
  logic [SW:0]   w_idx;
  state_t        w_next;
  logic          w_hit;

  assign w_idx  = {r_state, i_sequence_in};
  assign w_next = w_next_tbl[w_idx];
  assign w_hit  = w_hit_tbl[w_idx];

`ifdef SEQ_DET_COUNT_EN
  logic [COUNT_W-1:0] r_match_count;
  assign o_match_count = r_match_count;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S0;
      r_detector_out <= 1'b0;
`ifdef SEQ_DET_COUNT_EN
      r_match_count  <= '0;
`endif
    end else begin
      r_state        <= w_next;
      r_detector_out <= w_hit;
`ifdef SEQ_DET_COUNT_EN
      // Saturates at all-ones; only reset clears it.
      if (w_hit && (r_match_count != '1)) begin
        r_match_count <= r_match_count + COUNT_W'(1);
      end
`endif
    end
  end

  assign o_detector_out = r_detector_out;

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - self-checking bench for seq_detector

module tb_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;

  logic det_ovl, det_non, det_p11;
`ifdef SEQ_DET_COUNT_EN
  logic [1:0] cnt_ovl;
  logic [7:0] cnt_non, cnt_p11;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_step  = 0;

  always #5 clk = ~clk;

  // Instance 0: 1101 overlapping, 2-bit counter; 1: 1101 non-overlapping;
  // 2: pattern 11 overlapping.
  seq_detector #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b1), .COUNT_W(2)) u_ovl (
    .i_clk(clk), .i_rst(rst), .i_sequence_in(din), .o_detector_out(det_ovl)
`ifdef SEQ_DET_COUNT_EN
    , .o_match_count(cnt_ovl)
`endif
  );

  seq_detector #(.PATTERN_W(4), .PATTERN(4'b1101), .OVERLAP(1'b0), .COUNT_W(8)) u_non (
    .i_clk(clk), .i_rst(rst), .i_sequence_in(din), .o_detector_out(det_non)
`ifdef SEQ_DET_COUNT_EN
    , .o_match_count(cnt_non)
`endif
  );

  seq_detector #(.PATTERN_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .COUNT_W(8)) u_p11 (
    .i_clk(clk), .i_rst(rst), .i_sequence_in(din), .o_detector_out(det_p11)
`ifdef SEQ_DET_COUNT_EN
    , .o_match_count(cnt_p11)
`endif
  );

  // Reference model: a match is the last PW bits equalling the pattern, with
  // at least PW bits seen since reset (and, when non-overlapping, since the
  // previous match).
  int   m_pw   [3] = '{4, 4, 2};
  int   m_pat  [3] = '{13, 13, 3};
  int   m_ovl  [3] = '{1, 0, 1};
  int   m_cmax [3] = '{3, 255, 255};
  int   m_hist [3];
  int   m_since[3];
  int   m_cnt  [3];
  logic m_det  [3];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s step %0d: observed %0h expected %0h", tag, n_step, got, exp);
    end
  endtask

  task automatic step(input logic b, input logic r);
    din = b;
    rst = r;
    for (int m = 0; m < 3; m++) begin
      if (r) begin
        m_hist[m]  = 0;
        m_since[m] = 0;
        m_cnt[m]   = 0;
        m_det[m]   = 1'b0;
      end else begin
        m_hist[m]  = ((m_hist[m] << 1) | int'(b)) & 16'hFFFF;
        m_since[m] = m_since[m] + 1;
        m_det[m]   = (m_since[m] >= m_pw[m]) &&
                     ((m_hist[m] & ((1 << m_pw[m]) - 1)) == m_pat[m]);
        if (m_det[m]) begin
          if (m_ovl[m] == 0) m_since[m] = 0;
          if (m_cnt[m] < m_cmax[m]) m_cnt[m] = m_cnt[m] + 1;
        end
      end
    end
    @(posedge clk);
    #1;
    n_step++;
    check("det_ovl", {7'b0, det_ovl}, {7'b0, m_det[0]});
    check("det_non", {7'b0, det_non}, {7'b0, m_det[1]});
    check("det_p11", {7'b0, det_p11}, {7'b0, m_det[2]});
`ifdef SEQ_DET_COUNT_EN
    check("cnt_ovl", {6'b0, cnt_ovl}, 8'(m_cnt[0]));
    check("cnt_non", cnt_non, 8'(m_cnt[1]));
    check("cnt_p11", cnt_p11, 8'(m_cnt[2]));
`endif
  endtask

  task automatic feed(input logic [31:0] v, input int n);
    logic [31:0] t;
    t = v;
    for (int i = n - 1; i >= 0; i--) step(t[i], 1'b0);
  endtask

  initial begin
    // Reset held two cycles with data high.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Basic match: single pulse on edge 4.
    feed(32'b110111001111, 12);

    // Overlap sequence.
    step(1'b0, 1'b1);
    feed(32'b1101101, 7);

    // Prefix recovery.
    step(1'b0, 1'b1);
    feed(32'b11101, 5);

    // Mid-pattern reset discards progress.
    step(1'b0, 1'b1);
    feed(32'b110, 3);
    step(1'b1, 1'b1);
    feed(32'b1, 1);
    feed(32'b1101, 4);

    // Repeated pattern drives the counters into saturation.
    step(1'b0, 1'b1);
    for (int i = 0; i < 5; i++) feed(32'b1101, 4);

    // Back-to-back pulses for pattern 11.
    step(1'b0, 1'b1);
    feed(32'b111, 3);

    // Random traffic with occasional resets.
    step(1'b0, 1'b1);
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 31) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
